obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
Game controller that owns the obstacle table consumed by track_draw. It runs the game FSM (idle/play/crash) and, once per video frame, sweeps the table one slot per cycle to advance, retire, spawn and collision-check obstacles. Player lane and jump come from vision_process, already synchronised to the system clock. Sits between the vision path and track_draw on the 65 MHz system clock.

Parameters:
NUM_SLOTS, 10, obstacle table entries
SPAWN_POS, 1000, position loaded on spawn (distance from player)
BASE_SPEED, 4, position decrement per frame at game start
MAX_SPEED, 12, speed ceiling
SPEEDUP_EVERY, 8, retired obstacles per speed increment
SPAWN_INTERVAL, 60, frames between spawn attempts
HIT_WINDOW, 16, position below which the player's lane is checked

Ports:
system_clock_in  in  1  65 MHz system clock
reset_in  in  1  asynchronous, active-high reset
vsync_in  in  1  VGA vsync; rising edge = frame tick
start_in  in  1  one-cycle start/restart pulse
lane_in  in  2  player lane 0..2 (3 treated as 1)
jump_in  in  1  player jumping
obstacles  out  15 x NUM_SLOTS  entry {type[14:13], pos[12:3], lane[2:1], active[0]}
state_out  out  2  0 IDLE, 1 PLAY, 2 UPDATE, 3 CRASH
score_out  out  16  retired obstacles, saturating at 16'hFFFF
crash_out  out  1  high while in CRASH

Behaviour:
- Reset (async, from any state including mid-sweep): all obstacle entries 0, state IDLE, score 0, crash_out 0, speed BASE_SPEED, spawn countdown SPAWN_INTERVAL, LFSR 16'hACE1, vsync edge register 0.
- Frame tick: vsync_in registered once; tick = vsync_in & ~vsync_q. Ticks are used only in PLAY and ignored in every other state.
- IDLE: start_in -> PLAY. Clears the table, score, speed and countdown. A tick in the same cycle is ignored.
- PLAY: tick -> UPDATE. The countdown decrements, saturating at 0; spawn_pending is set when the countdown is 0 after the decrement. start_in is ignored.
- UPDATE: the slot index runs 0..NUM_SLOTS-1, one slot per cycle. The state returns after NUM_SLOTS+1 cycles (the last cycle resolves the crash flag).
  - Active slot with pos <= speed: cleared to 0 and score+1. This retire is not hit-checked.
  - Active slot otherwise: pos <= pos - speed. Hit if new pos < HIT_WINDOW, lane == effective lane_in, and not (type == 2'b00 and jump_in). A hit sets sticky crash_pending.
  - Inactive slot with spawn_pending: the lowest-index inactive slot is loaded with {type, SPAWN_POS, lane, 1}.
    - type = {1'b0, lfsr[2]}; lane = lfsr[1:0], with 3 mapped to 1; both sampled before the LFSR advances.
    - The LFSR then advances once (Galois, x^16+x^14+x^13+x^11+1). spawn_pending clears and the countdown reloads SPAWN_INTERVAL.
    - A newly spawned entry is not moved in this sweep.
  - No free slot: spawn_pending stays set and is retried next frame with the countdown held at 0.
  - Speed: after each retire, if the retire count mod SPEEDUP_EVERY == 0, speed = min(speed+1, MAX_SPEED).
  - End of sweep: crash_pending -> CRASH, otherwise -> PLAY.
- CRASH: table, score and speed are frozen; crash_out = 1. start_in -> IDLE, clearing the table and crash_out.
- Type 2'b00 is a low barrier (can be jumped). 2'b01 is a wall. Types 2'b1x are reserved and treated as wall.
- Obstacle entries and outputs are registered. Any table change is visible the cycle after its slot is processed.
- Arithmetic: pos is 10-bit unsigned and can never underflow because of the retire rule. speed is 4 bits wide.

Decomposition:
- Package game_pkg:
  - obstacle_t packed struct {type, pos, lane, active}, 15 bits, matching the track_draw layout.
  - game_state_t enum.
  - TYPE_LOW and TYPE_WALL constants.
  - LANE_LEFT/MID/RIGHT constants.
  - LFSR_SEED constant.
- Sub-module spawn_lfsr: 16-bit Galois LFSR with async reset to LFSR_SEED and an advance-enable input.

Test Plan:
- Reset -> obstacles all 0, state_out 0, score_out 0, crash_out 0. Assert reset for 1 cycle mid-UPDATE -> the same values immediately.
- SPAWN_INTERVAL=1, start_in, 1 tick -> slot0 = {2'b00, 1000, 2'b01, 1}. Next tick -> slot0 pos 996, and slot1 spawned with the LFSR-advanced values.
- SPAWN_INTERVAL=1, lane_in=1, jump_in=0, ticks until slot0 pos < 16 -> state_out 3, crash_out 1. Further ticks leave obstacles unchanged. start_in -> IDLE with the table cleared.
- Same stimulus with jump_in=1 -> no crash. slot0 retires when pos <= 4 (at pos 4, after 249 moves) -> score_out 1, slot0 = 0.
- All NUM_SLOTS active plus a pending spawn -> no load that frame. The spawn lands in the first slot freed on a later sweep.
- SPEEDUP_EVERY=1, retire 10 obstacles -> speed rises 4 -> 12 and stays at 12, checked via per-frame pos deltas.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg
// Obstacle entry layout, game states and constants shared with track_draw.
// Revision: 1.0
// ============================================================================
package game_pkg;

  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] pos;
    logic [1:0] lane;
    logic       active;
  } obstacle_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_CRASH  = 2'd3
  } game_state_t;

  localparam logic [1:0]  TYPE_LOW   = 2'b00;
  localparam logic [1:0]  TYPE_WALL  = 2'b01;
  localparam logic [1:0]  LANE_LEFT  = 2'd0;
  localparam logic [1:0]  LANE_MID   = 2'd1;
  localparam logic [1:0]  LANE_RIGHT = 2'd2;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Lane code 3 does not exist on the track; it folds onto the middle lane.
  function automatic logic [1:0] norm_lane(input logic [1:0] lane);
    return (lane > LANE_RIGHT) ? LANE_MID : lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spawn_lfsr.sv
`default_nettype none
// ============================================================================
// spawn_lfsr
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that randomises obstacle spawns.
// Revision: 1.0
// ============================================================================
module spawn_lfsr
  import game_pkg::*;
(
  input  logic        clk_65mhz,
  input  logic        rst,
  input  logic        i_advance,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk_65mhz or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_advance) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// obstacle_scheduler
// Game FSM plus per-frame sweep that moves, retires, spawns and hit-checks.
// Revision: 1.0
// ============================================================================
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS      = 10,
  parameter int SPAWN_POS      = 1000,
  parameter int BASE_SPEED     = 4,
  parameter int MAX_SPEED      = 12,
  parameter int SPEEDUP_EVERY  = 8,
  parameter int SPAWN_INTERVAL = 60,
  parameter int HIT_WINDOW     = 16
) (
  input  logic                    system_clock_in,
  input  logic                    reset_in,
  input  logic                    vsync_in,
  input  logic                    start_in,
  input  logic [1:0]              lane_in,
  input  logic                    jump_in,
  output logic [15*NUM_SLOTS-1:0] obstacles,
  output logic [1:0]              state_out,
  output logic [15:0]             score_out,
  output logic                    crash_out
);

  localparam int c_idx_w = $clog2(NUM_SLOTS + 1);
  localparam int c_cnt_w = $clog2(SPAWN_INTERVAL + 1);
  localparam int c_spd_w = $clog2(SPEEDUP_EVERY + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_SLOTS);

  game_state_t        r_state, w_state_next;
  obstacle_t          w_table [NUM_SLOTS];
  obstacle_t          w_cur, w_spawn_entry;
  logic [c_idx_w-1:0] r_idx;
  logic [c_cnt_w-1:0] r_countdown, w_countdown_dec;
  logic [c_spd_w-1:0] r_speedup_cnt;
  logic [3:0]         r_speed;
  logic [15:0]        r_score;
  logic               r_vsync_q, r_pending, r_crash_pending, r_crash;
  logic               w_tick, w_sweep, w_retire, w_move, w_hit, w_spawn, w_clear_table;
  logic [1:0]         w_lane;
  logic [9:0]         w_new_pos;
  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;

  spawn_lfsr u_lfsr (
    .clk_65mhz (system_clock_in),
    .rst       (reset_in),
    .i_advance (w_spawn),
    .o_lfsr    (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:3];

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_idx == c_idx_w'(i)) w_cur = w_table[i];
    end
  end

  // The speed register is updated on each retire, so later slots in the same sweep see it.
  assign w_tick          = vsync_in & ~r_vsync_q;
  assign w_lane          = norm_lane(lane_in);
  assign w_sweep         = (r_state == ST_UPDATE) && (r_idx < c_last_idx);
  assign w_retire        = w_sweep && w_cur.active && (w_cur.pos <= {6'd0, r_speed});
  assign w_move          = w_sweep && w_cur.active && !w_retire;
  assign w_new_pos       = w_cur.pos - {6'd0, r_speed};
  assign w_hit           = w_move && (w_new_pos < 10'(HIT_WINDOW)) && (w_cur.lane == w_lane)
                           && !((w_cur.kind == TYPE_LOW) && jump_in);
  assign w_spawn         = w_sweep && !w_cur.active && r_pending;
  assign w_clear_table   = start_in && ((r_state == ST_IDLE) || (r_state == ST_CRASH));
  assign w_countdown_dec = (r_countdown == '0) ? '0 : r_countdown - c_cnt_w'(1);

  always_comb begin
    w_spawn_entry        = '0;
    w_spawn_entry.kind   = w_lfsr[2] ? TYPE_WALL : TYPE_LOW;
    w_spawn_entry.pos    = 10'(SPAWN_POS);
    w_spawn_entry.lane   = norm_lane(w_lfsr[1:0]);
    w_spawn_entry.active = 1'b1;
  end

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_in) w_state_next = ST_PLAY;
      ST_PLAY:   if (w_tick)   w_state_next = ST_UPDATE;
      ST_UPDATE: if (r_idx == c_last_idx)
                   w_state_next = r_crash_pending ? ST_CRASH : ST_PLAY;
      ST_CRASH:  if (start_in) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_vsync_q       <= 1'b0;
      r_score         <= '0;
      r_speed         <= 4'(BASE_SPEED);
      r_speedup_cnt   <= '0;
      r_countdown     <= c_cnt_w'(SPAWN_INTERVAL);
      r_pending       <= 1'b0;
      r_crash_pending <= 1'b0;
      r_crash         <= 1'b0;
      r_idx           <= '0;
    end else begin
      r_vsync_q <= vsync_in;
      case (r_state)
        ST_IDLE: if (start_in) begin
          r_score         <= '0;
          r_speed         <= 4'(BASE_SPEED);
          r_speedup_cnt   <= '0;
          r_countdown     <= c_cnt_w'(SPAWN_INTERVAL);
          r_pending       <= 1'b0;
          r_crash_pending <= 1'b0;
          r_crash         <= 1'b0;
        end
        ST_PLAY: if (w_tick) begin
          r_idx           <= '0;
          r_crash_pending <= 1'b0;
          r_countdown     <= w_countdown_dec;
          if (w_countdown_dec == '0) r_pending <= 1'b1;
        end
        ST_UPDATE: begin
          r_idx <= r_idx + c_idx_w'(1);
          if (w_retire) begin
            if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
            if (r_speedup_cnt == c_spd_w'(SPEEDUP_EVERY - 1)) begin
              r_speedup_cnt <= '0;
              if (r_speed < 4'(MAX_SPEED)) r_speed <= r_speed + 4'd1;
            end else begin
              r_speedup_cnt <= r_speedup_cnt + c_spd_w'(1);
            end
          end
          if (w_hit) r_crash_pending <= 1'b1;
          if (w_spawn) begin
            r_pending   <= 1'b0;
            r_countdown <= c_cnt_w'(SPAWN_INTERVAL);
          end
          if (r_idx == c_last_idx) r_crash <= r_crash_pending;
        end
        ST_CRASH: if (start_in) r_crash <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    obstacle_t r_entry;
    logic      w_sel;

    assign w_sel = (r_idx == c_idx_w'(i));

    always_ff @(posedge system_clock_in or posedge reset_in) begin
      if (reset_in) begin
        r_entry <= '0;
      end else if (w_clear_table) begin
        r_entry <= '0;
      end else if (w_sel) begin
        if (w_retire)     r_entry     <= '0;
        else if (w_move)  r_entry.pos <= w_new_pos;
        else if (w_spawn) r_entry     <= w_spawn_entry;
      end
    end

    assign w_table[i]            = r_entry;
    assign obstacles[15*i +: 15] = r_entry;
  end

  assign state_out = r_state;
  assign score_out = r_score;
  assign crash_out = r_crash;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// tb_obstacle_scheduler
// Directed bench: spawn/move/retire, crash freeze, full table, speed ramp.
// Revision: 1.0
// ============================================================================
module tb_obstacle_scheduler;

  localparam int NS = 10;

  logic             clk = 1'b0;
  logic             rst, vsync, start, jump;
  logic [1:0]       lane;
  logic [15*NS-1:0] obs, obs_f;
  logic [1:0]       st, st_f;
  logic [15:0]      score, score_f;
  logic             crash, crash_f;
  int               n_cmp = 0;
  int               n_bad = 0;

  // Kind and lane of the first ten spawns from seed 16'hACE1
  int kinds [NS] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
  int lanes [NS] = '{1, 0, 0, 0, 2, 1, 1, 1, 0, 2};

  always #5 clk = ~clk;

  obstacle_scheduler #(.SPAWN_INTERVAL(1)) dut (
    .system_clock_in (clk),
    .reset_in        (rst),
    .vsync_in        (vsync),
    .start_in        (start),
    .lane_in         (lane),
    .jump_in         (jump),
    .obstacles       (obs),
    .state_out       (st),
    .score_out       (score),
    .crash_out       (crash)
  );

  // Hits can never fire here (moved pos is always >= 1), and every retire speeds up.
  obstacle_scheduler #(.SPAWN_INTERVAL(1), .SPEEDUP_EVERY(1), .HIT_WINDOW(1)) dut_fast (
    .system_clock_in (clk),
    .reset_in        (rst),
    .vsync_in        (vsync),
    .start_in        (start),
    .lane_in         (lane),
    .jump_in         (jump),
    .obstacles       (obs_f),
    .state_out       (st_f),
    .score_out       (score_f),
    .crash_out       (crash_f)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ent(input int kind, input int pos, input int ln);
    return {kind[1:0], pos[9:0], ln[1:0], 1'b1};
  endfunction

  function automatic logic [14:0] slot(input logic [15*NS-1:0] t, input int i);
    return t[15*i +: 15];
  endfunction

  // Slot k spawns on frame k+1 and moves 4 per frame afterwards (valid before any retire).
  function automatic logic [15*NS-1:0] table_at(input int f);
    logic [15*NS-1:0] t;
    t = '0;
    for (int k = 0; k < NS; k++) t[15*k +: 15] = ent(kinds[k], 1000 - 4*(f-1-k), lanes[k]);
    return t;
  endfunction

  task automatic frame();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; start = 1'b0; lane = 2'd1; jump = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_table", obs, 0);
    check("rst_state", st, 0);
    check("rst_score", score, 0);
    check("rst_crash", crash, 0);
    rst = 1'b0;

    frame();
    check("idle_tick_ignored", st, 0);
    pulse_start();
    check("start_play", st, 1);
    frame();
    check("spawn_slot0", slot(obs, 0), ent(0, 1000, 1));
    check("slot1_empty", slot(obs, 1), 0);
    check("sweep_back_play", st, 1);
    pulse_start();
    check("start_ignored_play", st, 1);
    frame();
    check("slot0_move", slot(obs, 0), ent(0, 996, 1));
    check("slot1_spawn", slot(obs, 1), ent(0, 1000, 0));

    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_update", st, 2);
    #1 rst = 1'b1;
    #1;
    check("midrst_table", obs, 0);
    check("midrst_state", st, 0);
    check("midrst_score", score, 0);
    check("midrst_crash", crash, 0);
    @(negedge clk); rst = 1'b0;

    // Lane 1, no jump: slot0 (low barrier, lane 1) enters the hit window on frame 248
    pulse_start();
    frames(11);
    check("full_no_load", obs, table_at(11));
    frame();
    check("full_retry", obs, table_at(12));
    frames(235);
    check("pre_crash_slot0", slot(obs, 0), ent(0, 16, 1));
    check("pre_crash_state", st, 1);
    check("pre_crash_flag", crash, 0);
    frame();
    check("crash_state", st, 3);
    check("crash_flag", crash, 1);
    check("crash_table", obs, table_at(248));
    frames(3);
    check("frozen_table", obs, table_at(248));
    check("frozen_state", st, 3);
    check("frozen_score", score, 0);
    pulse_start();
    check("crash_to_idle", st, 0);
    check("idle_table", obs, 0);
    check("idle_crash", crash, 0);

    // Lane 1, jumping: low barriers pass, slot0 retires at pos 4
    do_reset();
    jump = 1'b1;
    pulse_start();
    frames(250);
    check("f250_table", obs, table_at(250));
    check("f250_table_fast", obs_f, table_at(250));
    frame();
    check("retire_score", score, 1);
    check("retire_slot0", slot(obs, 0), 0);
    check("retire_slot1", slot(obs, 1), ent(0, 4, 0));
    check("retire_state", st, 1);
    check("retire_crash", crash, 0);
    check("fast_score1", score_f, 1);
    check("fast_slot1_sp5", slot(obs_f, 1), ent(0, 3, 0));
    frame();
    check("freed_spawn", slot(obs, 0), ent(0, 1000, 1));
    check("score2", score, 2);
    check("state_f252", st, 1);
    check("fast_spawn", slot(obs_f, 0), ent(0, 1000, 1));
    check("fast_slot2_sp6", slot(obs_f, 2), ent(0, 1, 0));
    check("fast_score2", score_f, 2);
    frame();
    check("fast_pos_sp6", slot(obs_f, 0), ent(0, 994, 1));
    check("fast_slot1_spawn", slot(obs_f, 1), ent(0, 1000, 0));
    check("fast_score4", score_f, 4);
    frame();
    check("fast_pos_sp8", slot(obs_f, 0), ent(0, 986, 1));
    check("fast_score7", score_f, 7);
    frame();
    check("fast_pos_sp11", slot(obs_f, 0), ent(0, 975, 1));
    check("fast_score10", score_f, 10);
    frame();
    check("fast_pos_sp12", slot(obs_f, 0), ent(0, 963, 1));
    frame();
    check("fast_pos_cap12", slot(obs_f, 0), ent(0, 951, 1));
    check("fast_state", st_f, 1);
    check("fast_crash", crash_f, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
